// File: rtl/status_flag_stack.sv
// Processor status register with a circular shadow stack for nested context save/restore.
// Per-bit flag sources are priority-muxed, then forced through fixed one/zero masks.
module status_flag_stack #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] ONE_MASK  = 8'h20,
  parameter logic [WIDTH-1:0] ZERO_MASK = 8'h10,
  parameter int unsigned      Z_BIT     = 1,
  parameter int unsigned      BRK_BIT   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           db_in,
  input  logic [WIDTH-1:0]           db_we,
  input  logic [WIDTH-1:0]           man_we,
  input  logic                       man_val,
  input  logic [WIDTH-1:0]           alu_we,
  input  logic [WIDTH-1:0]           alu_flags,
  input  logic                       zero_we,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       push_brk,
  input  logic                       break_set,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           flags_out,
  output logic [WIDTH-1:0]           stack_top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int unsigned     DW     = $clog2(DEPTH + 1);
  localparam int unsigned     PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);
  localparam logic [DW-1:0]   Full   = DW'(DEPTH);

  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d, ptr_next, ptr_prev, wr_ptr;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             ovf_ev, udf_ev, wr_en, empty, full;
  logic [WIDTH-1:0] upd, push_val, top_val;

  function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] v);
    return (v & ~ZERO_MASK) | ONE_MASK;
  endfunction

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == Full);
  assign top_val  = mem_q[ptr_q];
  assign ptr_next = (ptr_q == PtrMax) ? '0 : ptr_q + PtrW'(1);
  assign ptr_prev = (ptr_q == '0) ? PtrMax : ptr_q - PtrW'(1);

  // Priority per bit: ALU, zero test (Z only), manual, data bus, hold.
  always_comb begin
    upd = flags_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (alu_we[i]) begin
        upd[i] = alu_flags[i];
      end else if ((i == Z_BIT) && zero_we) begin
        upd[i] = (db_in == '0);
      end else if (man_we[i]) begin
        upd[i] = man_val;
      end else if (db_we[i]) begin
        upd[i] = db_in[i];
      end
    end
  end

  always_comb begin
    push_val          = flags_q;
    push_val[BRK_BIT] = push_brk;
    push_val          = push_val | ONE_MASK;
  end

  always_comb begin
    flags_d = apply_mask(upd);
    ptr_d   = ptr_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_ptr  = ptr_q;
    ovf_ev  = 1'b0;
    udf_ev  = 1'b0;
    if (push && pop && !empty) begin
      // Swap: current image replaces the top entry in place.
      flags_d = apply_mask(top_val);
      wr_en   = 1'b1;
    end else if (push) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_next;
      ptr_d  = ptr_next;
      udf_ev = pop;
      if (full) begin
        ovf_ev = 1'b1;
      end else begin
        depth_d = depth_q + DW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        udf_ev = 1'b1;
      end else begin
        flags_d = apply_mask(top_val);
        ptr_d   = ptr_prev;
        depth_d = depth_q - DW'(1);
      end
    end
    ovf_d = ovf_ev | (ovf_q & ~err_clr);
    udf_d = udf_ev | (udf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= ONE_MASK;
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      if (wr_en) begin
        mem_q[wr_ptr] <= push_val;
      end
    end
  end

  always_comb begin
    flags_out          = flags_q;
    flags_out[BRK_BIT] = break_set;
    flags_out          = flags_out | ONE_MASK;
  end

  assign stack_top = empty ? '0 : top_val;
  assign depth     = depth_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;

endmodule

// File: tb/tb_status_flag_stack.sv
// Directed bench for status_flag_stack with hand-computed expectations.
module tb_status_flag_stack;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] db_in, db_we, man_we, alu_we, alu_flags;
  logic       man_val, zero_we, push, pop, push_brk, break_set, err_clr;
  logic [7:0] flags_out, stack_top;
  logic [2:0] depth;
  logic       ovf_err, udf_err;

  int passed = 0;
  int total  = 0;

  status_flag_stack dut (
    .clk       (clk),
    .rst       (rst),
    .db_in     (db_in),
    .db_we     (db_we),
    .man_we    (man_we),
    .man_val   (man_val),
    .alu_we    (alu_we),
    .alu_flags (alu_flags),
    .zero_we   (zero_we),
    .push      (push),
    .pop       (pop),
    .push_brk  (push_brk),
    .break_set (break_set),
    .err_clr   (err_clr),
    .flags_out (flags_out),
    .stack_top (stack_top),
    .depth     (depth),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    rst = 1'b0; db_in = '0; db_we = '0; man_we = '0; alu_we = '0; alu_flags = '0;
    man_val = 1'b0; zero_we = 1'b0; push = 1'b0; pop = 1'b0; push_brk = 1'b0;
    break_set = 1'b0; err_clr = 1'b0;
  endtask

  // Advance one edge, sample 1 time unit later, then release all inputs.
  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic load(input logic [7:0] v);
    db_in = v; db_we = 8'hFF;
    step();
  endtask

  task automatic chk_all(input string tag, input logic [7:0] f, input logic [7:0] t,
                         input logic [2:0] d, input logic o, input logic u);
    check({tag, ".flags"}, 32'(flags_out), 32'(f));
    check({tag, ".top"},   32'(stack_top), 32'(t));
    check({tag, ".depth"}, 32'(depth),     32'(d));
    check({tag, ".ovf"},   32'(ovf_err),   32'(o));
    check({tag, ".udf"},   32'(udf_err),   32'(u));
  endtask

  initial begin
    logic [7:0] pv [5];
    logic [7:0] rv [4];
    pv[0] = 8'h21; pv[1] = 8'h22; pv[2] = 8'h24; pv[3] = 8'h28; pv[4] = 8'h60;
    rv[0] = 8'h60; rv[1] = 8'h28; rv[2] = 8'h24; rv[3] = 8'h22;

    clr();
    #2;
    rst = 1'b1;
    step();
    step();
    chk_all("reset", 8'h20, 8'h00, 3'd0, 1'b0, 1'b0);

    // Priority mux and masks
    db_in = 8'hCF; db_we = 8'hFF;
    #1;
    check("no_comb_path", 32'(flags_out), 32'h20);
    step();
    check("db_load", 32'(flags_out), 32'hEF);
    alu_we = 8'h01; alu_flags = 8'h00; man_we = 8'h01; man_val = 1'b1;
    step();
    check("alu_over_man", 32'(flags_out), 32'hEE);

    // Zero test
    load(8'h20);
    db_in = 8'h00; zero_we = 1'b1;
    step();
    check("zero_set", 32'(flags_out), 32'h22);
    db_in = 8'h05; zero_we = 1'b1;
    step();
    check("zero_clr", 32'(flags_out), 32'h20);
    break_set = 1'b1;
    #1;
    check("break_out", 32'(flags_out), 32'h30);
    break_set = 1'b0;

    // Push with same-cycle update, then pop overriding enables
    load(8'hA1);
    push = 1'b1; push_brk = 1'b1; db_we = 8'h80; db_in = 8'h00;
    step();
    chk_all("push1", 8'h21, 8'hB1, 3'd1, 1'b0, 1'b0);
    pop = 1'b1; alu_we = 8'hFF; alu_flags = 8'h00;
    step();
    chk_all("pop1", 8'hA1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Overflow wraps, pops return newest first, then underflow
    for (int i = 0; i < 5; i++) begin
      load(pv[i]);
      push = 1'b1;
      step();
      if (i == 3) chk_all("push4", 8'h28, 8'h28, 3'd4, 1'b0, 1'b0);
    end
    chk_all("push5_ovf", 8'h60, 8'h60, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      step();
      check($sformatf("pop_order%0d", i), 32'(flags_out), 32'(rv[i]));
      check($sformatf("pop_depth%0d", i), 32'(depth), 32'(3 - i));
    end
    pop = 1'b1;
    step();
    chk_all("pop_udf", 8'h22, 8'h00, 3'd0, 1'b1, 1'b1);
    err_clr = 1'b1;
    step();
    chk_all("err_clr", 8'h22, 8'h00, 3'd0, 1'b0, 1'b0);

    // Swap at depth 1
    load(8'h61);
    push = 1'b1;
    step();
    load(8'h23);
    push = 1'b1; pop = 1'b1; alu_we = 8'hFF;
    step();
    chk_all("swap", 8'h61, 8'h23, 3'd1, 1'b0, 1'b0);

    // Reset overrides a push
    rst = 1'b1; push = 1'b1;
    step();
    chk_all("mid_reset", 8'h20, 8'h00, 3'd0, 1'b0, 1'b0);

    // Push+pop while empty acts as push and flags underflow
    push = 1'b1; pop = 1'b1;
    step();
    chk_all("pushpop_empty", 8'h20, 8'h20, 3'd1, 1'b0, 1'b1);
    pop = 1'b1;
    step();
    check("pop_to_empty", 32'(depth), 32'd0);
    err_clr = 1'b1; pop = 1'b1;
    step();
    check("err_clr_loses", 32'(udf_err), 32'd1);
    err_clr = 1'b1;
    step();
    check("err_clr_final", 32'(udf_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
